// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - eight-digit seven-segment scan controller with
// leading-zero suppression, per-digit blink and non-BCD blanking.
module seg_scan #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] value,
  input  logic        lz_en,
  input  logic [7:0]  blink_mask,
  output logic [3:0]  num,
  output logic [7:0]  an,
  output logic        digit_blank
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

  logic [31:0]   shadow_q, shadow_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          blink_q, blink_d;
  logic [3:0]    num_q, num_d;
  logic [7:0]    an_q, an_d;
  logic          blank_q, blank_d;

  logic          tick;
  logic          frame_end;
  logic [3:0]    cur_nib;
  logic          bcd_blank;
  logic          lz_blank;
  logic          blink_blank;
  logic          blank_now;

  always_comb begin
    shadow_d  = load ? value : shadow_q;

    tick      = (presc_q == PRESC_LAST);
    presc_d   = tick ? '0 : presc_q + 1'b1;
    idx_d     = tick ? idx_q + 3'd1 : idx_q;

    frame_end = tick && (idx_q == 3'd7);
    frame_d   = frame_q;
    blink_d   = blink_q;
    if (frame_end) begin
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  // Digit 0 is exempt from zero suppression so a zero value still shows "0".
  always_comb begin
    cur_nib     = shadow_q[{idx_q, 2'b00} +: 4];
    bcd_blank   = (cur_nib > 4'd9);
    lz_blank    = lz_en && (idx_q != 3'd0) &&
                  ((shadow_q >> {idx_q, 2'b00}) == 32'd0);
    blink_blank = blink_mask[idx_q] && blink_q;
    blank_now   = bcd_blank || lz_blank || blink_blank;

    num_d       = blank_now ? 4'd0 : cur_nib;
    an_d        = blank_now ? 8'h00 : (8'b1 << idx_q);
    blank_d     = blank_now;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q <= '0;
      presc_q  <= '0;
      idx_q    <= '0;
      frame_q  <= '0;
      blink_q  <= 1'b0;
      num_q    <= 4'd0;
      an_q     <= 8'h00;
      blank_q  <= 1'b1;
    end else begin
      shadow_q <= shadow_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
      blink_q  <= blink_d;
      num_q    <= num_d;
      an_q     <= an_d;
      blank_q  <= blank_d;
    end
  end

  assign num         = num_q;
  assign an          = an_q;
  assign digit_blank = blank_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - directed self-checking bench for seg_scan
// (SCAN_DIV=4, BLINK_DIV=2).
module tb_seg_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [31:0] value;
  logic        lz_en;
  logic [7:0]  blink_mask;
  logic [3:0]  num;
  logic [7:0]  an;
  logic        digit_blank;

  int tests = 0;
  int fails = 0;
  int n = 0;

  seg_scan #(.SCAN_DIV(4), .BLINK_DIV(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .value(value),
    .lz_en(lz_en),
    .blink_mask(blink_mask),
    .num(num),
    .an(an),
    .digit_blank(digit_blank)
  );

  always #5 clk = ~clk;

  // Output after edge n (n counted from reset release) shows digit ((n-1)/4)%8.
  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic start(input logic [31:0] v, input logic lz, input logic [7:0] m);
    rst_n = 1'b0;
    load = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    value = v;
    load = 1'b1;
    lz_en = lz;
    blink_mask = m;
    step();
    load = 1'b0;
    n = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    load = 1'b1;
    value = 32'hFFFF_FFFF;
    lz_en = 1'b0;
    blink_mask = 8'h00;
    for (int k = 0; k < 3; k++) begin
      step();
      tests++;
      if ({an, num, digit_blank} !== {8'h00, 4'h0, 1'b1}) begin
        fails++;
        $display("FAIL reset cyc%0d: an=%h num=%h blank=%b, expected an=00 num=0 blank=1",
                 k, an, num, digit_blank);
      end
    end
    // load was high during reset; the shadow must still be zero
    load = 1'b0;
    rst_n = 1'b1;
    step();
    tests++;
    if ({an, num, digit_blank} !== {8'h01, 4'h0, 1'b0}) begin
      fails++;
      $display("FAIL reset_over_load: an=%h num=%h blank=%b, expected an=01 num=0 blank=0",
               an, num, digit_blank);
    end
  endtask

  task automatic test_scan();
    int d;
    logic [7:0] ea;
    logic [3:0] en;
    start(32'h8765_4321, 1'b0, 8'h00);
    for (int k = 2; k <= 72; k++) begin
      step();
      d = ((n - 1) / 4) % 8;
      ea = 8'(1 << d);
      en = 4'(d + 1);
      tests++;
      if ({an, num, digit_blank} !== {ea, en, 1'b0}) begin
        fails++;
        $display("FAIL scan n=%0d: an=%h num=%h blank=%b, expected an=%h num=%h blank=0",
                 n, an, num, digit_blank, ea, en);
      end
    end
  endtask

  task automatic test_lz();
    int d;
    logic [7:0] ea;
    logic [3:0] en;
    logic [3:0] tnum [8];
    logic [7:0] tshow;
    tnum = '{4'd5, 4'd0, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    tshow = 8'b0000_0111;
    start(32'h0000_0305, 1'b1, 8'h00);
    for (int k = 2; k <= 33; k++) begin
      step();
      d = ((n - 1) / 4) % 8;
      ea = tshow[d] ? 8'(1 << d) : 8'h00;
      en = tshow[d] ? tnum[d] : 4'd0;
      tests++;
      if ({an, num, digit_blank} !== {ea, en, ~tshow[d]}) begin
        fails++;
        $display("FAIL lz_305 n=%0d: an=%h num=%h blank=%b, expected an=%h num=%h blank=%b",
                 n, an, num, digit_blank, ea, en, ~tshow[d]);
      end
    end
    start(32'h0, 1'b1, 8'h00);
    for (int k = 2; k <= 33; k++) begin
      step();
      d = ((n - 1) / 4) % 8;
      ea = (d == 0) ? 8'h01 : 8'h00;
      tests++;
      if ({an, num, digit_blank} !== {ea, 4'd0, (d != 0)}) begin
        fails++;
        $display("FAIL lz_zero n=%0d: an=%h num=%h blank=%b, expected an=%h num=0 blank=%b",
                 n, an, num, digit_blank, ea, (d != 0));
      end
    end
  endtask

  task automatic test_nonbcd();
    int d;
    logic [7:0] ea;
    logic [3:0] en;
    logic [3:0] tnum [8];
    logic [7:0] tshow;
    tnum = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    tshow = 8'b1111_0101;
    start(32'h0000_A0B1, 1'b0, 8'h00);
    for (int k = 2; k <= 33; k++) begin
      step();
      d = ((n - 1) / 4) % 8;
      ea = tshow[d] ? 8'(1 << d) : 8'h00;
      en = tshow[d] ? tnum[d] : 4'd0;
      tests++;
      if ({an, num, digit_blank} !== {ea, en, ~tshow[d]}) begin
        fails++;
        $display("FAIL nonbcd n=%0d: an=%h num=%h blank=%b, expected an=%h num=%h blank=%b",
                 n, an, num, digit_blank, ea, en, ~tshow[d]);
      end
    end
  endtask

  task automatic test_blink();
    int d;
    int f;
    logic hide;
    logic [7:0] ea;
    logic [3:0] en;
    start(32'h1111_1111, 1'b0, 8'h01);
    for (int k = 2; k <= 192; k++) begin
      step();
      d = ((n - 1) / 4) % 8;
      f = (n - 1) / 32;
      hide = (d == 0) && (((f / 2) % 2) == 1);
      ea = hide ? 8'h00 : 8'(1 << d);
      en = hide ? 4'd0 : 4'd1;
      tests++;
      if ({an, num, digit_blank} !== {ea, en, hide}) begin
        fails++;
        $display("FAIL blink n=%0d frame=%0d: an=%h num=%h blank=%b, expected an=%h num=%h blank=%b",
                 n, f, an, num, digit_blank, ea, en, hide);
      end
    end
  endtask

  task automatic test_mid_load();
    logic [7:0] ea [5];
    logic [3:0] en [5];
    ea = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h10};
    en = '{4'd3, 4'd3, 4'd2, 4'd2, 4'd2};
    start(32'h3333_3333, 1'b0, 8'h00);
    while (n < 12) step();
    for (int k = 0; k < 5; k++) begin
      // load lands on the edge that produces the 2nd output cycle of digit 3
      if (k == 1) begin
        load = 1'b1;
        value = 32'h2222_2222;
      end
      step();
      load = 1'b0;
      tests++;
      if ({an, num, digit_blank} !== {ea[k], en[k], 1'b0}) begin
        fails++;
        $display("FAIL mid_load n=%0d: an=%h num=%h blank=%b, expected an=%h num=%h blank=0",
                 n, an, num, digit_blank, ea[k], en[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int d;
    logic hide;
    logic [7:0] ea;
    start(32'h1111_1111, 1'b0, 8'hFF);
    while (n < 86) step();
    tests++;
    if ({an, digit_blank} !== {8'h00, 1'b1}) begin
      fails++;
      $display("FAIL pre_reset_blink n=%0d: an=%h blank=%b, expected an=00 blank=1",
               n, an, digit_blank);
    end
    rst_n = 1'b0;
    step();
    tests++;
    if ({an, num, digit_blank} !== {8'h00, 4'h0, 1'b1}) begin
      fails++;
      $display("FAIL reset_mid: an=%h num=%h blank=%b, expected an=00 num=0 blank=1",
               an, num, digit_blank);
    end
    rst_n = 1'b1;
    n = 0;
    for (int k = 1; k <= 65; k++) begin
      step();
      d = ((n - 1) / 4) % 8;
      hide = (n > 64);
      ea = hide ? 8'h00 : 8'(1 << d);
      tests++;
      if ({an, num, digit_blank} !== {ea, 4'd0, hide}) begin
        fails++;
        $display("FAIL post_reset n=%0d: an=%h num=%h blank=%b, expected an=%h num=0 blank=%b",
                 n, an, num, digit_blank, ea, hide);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    load = 1'b0;
    value = 32'h0;
    lz_en = 1'b0;
    blink_mask = 8'h00;
    test_reset();
    test_scan();
    test_lz();
    test_nonbcd();
    test_blink();
    test_mid_load();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
